// File: rtl/video_pkg.sv
// Shared types and constants for the video timing / test-pattern block.
//   mode_e      : pixel source selection (stream or one of three patterns)
//   rgb_t       : RGB888 pixel, r in the top byte
//   COL_*       : the eight colour-bar colours, left to right
//   bar_colour  : maps a bar index 0..7 to its colour
package video_pkg;

    typedef enum logic [1:0] {
        MODE_STREAM  = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_GRID    = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_WHITE   = 24'hFFFFFF;
    localparam rgb_t COL_YELLOW  = 24'hFFFF00;
    localparam rgb_t COL_CYAN    = 24'h00FFFF;
    localparam rgb_t COL_GREEN   = 24'h00FF00;
    localparam rgb_t COL_MAGENTA = 24'hFF00FF;
    localparam rgb_t COL_RED     = 24'hFF0000;
    localparam rgb_t COL_BLUE    = 24'h0000FF;
    localparam rgb_t COL_BLACK   = 24'h000000;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters and timing decode.
//   clk_i, rst_ni          : pixel clock, synchronous active-low reset
//   active_o               : current position is inside the active area (combinational)
//   frame_first_o          : position is (0,0) (combinational)
//   frame_last_o           : position is the last one of the frame (combinational)
//   line_last_o            : position is the last one of a line (combinational)
//   x_lo_o, y_lo_o         : low five bits of the current x / y (zero-extended)
//   hs_n_o, vs_n_o, de_o   : registered syncs (active low) and data enable
//   frame_start_o          : registered pulse for pixel (0,0)
//   line_start_o           : registered pulse for x=0 of every active line
module video_timing_counter #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
    localparam int HW     = $clog2(HTOTAL),
    localparam int VW     = $clog2(VTOTAL)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       active_o,
    output logic       frame_first_o,
    output logic       frame_last_o,
    output logic       line_last_o,
    output logic [4:0] x_lo_o,
    output logic [4:0] y_lo_o,
    output logic       hs_n_o,
    output logic       vs_n_o,
    output logic       de_o,
    output logic       frame_start_o,
    output logic       line_start_o
);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hs_n_q, vs_n_q, de_q, frame_start_q, line_start_q;

    int  hpos, vpos;
    logic hlast, vlast, hact, vact, hsync, vsync;

    // Decode in plain integer space so that bounds equal to a power of two
    // never alias through a narrow counter width.
    always_comb begin
        hpos  = int'(hcnt_q);
        vpos  = int'(vcnt_q);
        hlast = (hpos == HTOTAL - 1);
        vlast = (vpos == VTOTAL - 1);
        hact  = (hpos < HDISP);
        vact  = (vpos < VDISP);
        hsync = (hpos >= HDISP + HFP) && (hpos < HDISP + HFP + HPULSE);
        vsync = (vpos >= VDISP + VFP) && (vpos < VDISP + VFP + VPULSE);
    end

    always_comb begin
        hcnt_d = hlast ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hlast) begin
            vcnt_d = vlast ? '0 : vcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hs_n_q        <= 1'b1;
            vs_n_q        <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_n_q        <= ~hsync;
            vs_n_q        <= ~vsync;
            de_q          <= hact && vact;
            frame_start_q <= (hcnt_q == '0) && (vcnt_q == '0);
            line_start_q  <= (hcnt_q == '0) && vact;
        end
    end

    assign active_o      = hact && vact;
    assign frame_first_o = (hcnt_q == '0) && (vcnt_q == '0);
    assign frame_last_o  = hlast && vlast;
    assign line_last_o   = hlast;
    assign x_lo_o        = 5'(hcnt_q);
    assign y_lo_o        = 5'(vcnt_q);
    assign hs_n_o        = hs_n_q;
    assign vs_n_o        = vs_n_q;
    assign de_o          = de_q;
    assign frame_start_o = frame_start_q;
    assign line_start_o  = line_start_q;

endmodule

// File: rtl/video_timing_pattern.sv
// Video timing generator with stream / test-pattern pixel source.
//   pixel_clk, pixel_rst_n : pixel clock, synchronous active-low reset
//   mode                   : pixel source, taken at the start of each frame
//   pix_data, pix_valid    : show-ahead upstream pixel and its valid flag
//   pix_req                : pops one upstream pixel (combinational)
//   underflow_clr          : clears the sticky underflow flag
//   hs_n, vs_n, de         : registered syncs (active low) and data enable
//   rgb                    : registered output pixel
//   frame_start, line_start: registered markers aligned with rgb
//   underflow              : sticky flag, set when a pop finds no data
module video_timing_pattern
    import video_pkg::*;
#(
    parameter int          HDISP           = 800,
    parameter int          VDISP           = 480,
    parameter int          HFP             = 40,
    parameter int          HPULSE          = 48,
    parameter int          HBP             = 40,
    parameter int          VFP             = 13,
    parameter int          VPULSE          = 3,
    parameter int          VBP             = 29,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [1:0]  mode,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_req,
    input  logic        underflow_clr,
    output logic        hs_n,
    output logic        vs_n,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        line_start,
    output logic        underflow
);

    localparam int BARW = HDISP / 8;
    localparam int BW   = $clog2(BARW + 1);

    logic       active, frame_first, frame_last, line_last;
    logic [4:0] x_lo, y_lo;

    video_timing_counter #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .HFP   (HFP),
        .HPULSE(HPULSE),
        .HBP   (HBP),
        .VFP   (VFP),
        .VPULSE(VPULSE),
        .VBP   (VBP)
    ) u_counter (
        .clk_i        (pixel_clk),
        .rst_ni       (pixel_rst_n),
        .active_o     (active),
        .frame_first_o(frame_first),
        .frame_last_o (frame_last),
        .line_last_o  (line_last),
        .x_lo_o       (x_lo),
        .y_lo_o       (y_lo),
        .hs_n_o       (hs_n),
        .vs_n_o       (vs_n),
        .de_o         (de),
        .frame_start_o(frame_start),
        .line_start_o (line_start)
    );

    mode_e          mode_q, mode_eff;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]  bar_pix_q, bar_pix_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    rgb_t           rgb_q, rgb_d;
    logic           underflow_q, underflow_d;
    logic [3:0]     grid_x;

    // The mode input is taken at (0,0) and already governs that first pixel,
    // so the new mode and the frame_start marker appear together.
    assign mode_eff = frame_first ? mode_e'(mode) : mode_q;

    assign pix_req = pixel_rst_n && active && (mode_eff == MODE_STREAM);

    // Bar position tracks x: bar_idx = min(x / BARW, 7), restarted each line.
    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        if (line_last) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (active) begin
            if (int'(bar_pix_q) == BARW - 1) begin
                bar_pix_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_pix_d = bar_pix_q + 1'b1;
            end
        end
    end

    always_comb begin
        frame_cnt_d = frame_last ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // A new underflow wins over a simultaneous clear.
    always_comb begin
        underflow_d = underflow_q;
        if (pix_req && !pix_valid) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_comb begin
        rgb_d  = COL_BLACK;
        grid_x = x_lo[3:0] + frame_cnt_q[3:0];
        if (active) begin
            case (mode_eff)
                MODE_STREAM:  rgb_d = pix_valid ? rgb_t'(pix_data) : rgb_t'(UNDERFLOW_COLOR);
                MODE_BARS:    rgb_d = bar_colour(bar_idx_q);
                MODE_CHECKER: rgb_d = (x_lo[4] ^ y_lo[4]) ? COL_WHITE : COL_BLACK;
                MODE_GRID:    rgb_d = ((grid_x == 4'd0) || (y_lo[3:0] == 4'd0)) ? COL_WHITE : COL_BLACK;
                default:      rgb_d = COL_BLACK;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            mode_q      <= MODE_STREAM;
            frame_cnt_q <= '0;
            bar_pix_q   <= '0;
            bar_idx_q   <= '0;
            rgb_q       <= COL_BLACK;
            underflow_q <= 1'b0;
        end else begin
            mode_q      <= mode_eff;
            frame_cnt_q <= frame_cnt_d;
            bar_pix_q   <= bar_pix_d;
            bar_idx_q   <= bar_idx_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign rgb       = rgb_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_video_timing_pattern.sv
module tb_video_timing_pattern;

    typedef struct packed {
        int hd; int vd; int hfp; int hp; int hbp; int vfp; int vp; int vbp;
    } tp_t;

    localparam tp_t P1  = '{161, 90, 2, 3, 4, 1, 2, 3};
    localparam int  HT1 = 170;
    localparam int  VT1 = 96;
    localparam tp_t P2  = '{8, 2, 1, 1, 1, 1, 1, 1};
    localparam int  HT2 = 11;
    localparam int  VT2 = 5;
    localparam logic [29:0] RST_EXP = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_col(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference pixel for position (h,v) under frame mode m.
    function automatic logic [23:0] ref_pixel(input tp_t p, input int h, input int v, input int fc,
                                              input int m, input logic valid, input logic [23:0] data);
        int b;
        if (h >= p.hd || v >= p.vd) return 24'h0;
        case (m)
            0: return valid ? data : 24'hFF00FF;
            1: begin
                b = h / (p.hd / 8);
                if (b > 7) b = 7;
                return bar_col(b);
            end
            2: return ((((h / 16) + (v / 16)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
            default: return ((((h + fc) % 16) == 0) || ((v % 16) == 0)) ? 24'hFFFFFF : 24'h0;
        endcase
    endfunction

    // Expected {hs_n, vs_n, de, frame_start, line_start, underflow, rgb}.
    function automatic logic [29:0] ref_out(input tp_t p, input int h, input int v, input int fc,
                                            input int m, input logic valid, input logic [23:0] data,
                                            input logic uf);
        logic hs, vs, act, fs, ls;
        act = (h < p.hd) && (v < p.vd);
        hs  = !((h >= p.hd + p.hfp) && (h < p.hd + p.hfp + p.hp));
        vs  = !((v >= p.vd + p.vfp) && (v < p.vd + p.vfp + p.vp));
        fs  = (h == 0) && (v == 0);
        ls  = (h == 0) && (v < p.vd);
        return {hs, vs, act, fs, ls, uf, ref_pixel(p, h, v, fc, m, valid, data)};
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT with the reduced test resolution.
    logic        pixel_rst_n, pix_valid, underflow_clr, pix_req;
    logic [1:0]  mode;
    logic [23:0] pix_data, rgb;
    logic        hs_n, vs_n, de, frame_start, line_start, underflow;

    video_timing_pattern #(
        .HDISP(161), .VDISP(90), .HFP(2), .HPULSE(3), .HBP(4),
        .VFP(1), .VPULSE(2), .VBP(3), .UNDERFLOW_COLOR(24'hFF00FF)
    ) dut (
        .pixel_clk(clk), .pixel_rst_n(pixel_rst_n), .mode(mode),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_req(pix_req),
        .underflow_clr(underflow_clr), .hs_n(hs_n), .vs_n(vs_n), .de(de),
        .rgb(rgb), .frame_start(frame_start), .line_start(line_start),
        .underflow(underflow)
    );

    // Tiny raster so hundreds of frames fit in the run (frame counter wrap).
    logic        rst2_n, valid2, clr2, req2;
    logic [1:0]  mode2;
    logic [23:0] data2, rgb2;
    logic        hs2_n, vs2_n, de2, fs2, ls2, uf2;
    logic        tiny_done = 1'b0;

    video_timing_pattern #(
        .HDISP(8), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1), .UNDERFLOW_COLOR(24'hFF00FF)
    ) dut_tiny (
        .pixel_clk(clk), .pixel_rst_n(rst2_n), .mode(mode2),
        .pix_data(data2), .pix_valid(valid2), .pix_req(req2),
        .underflow_clr(clr2), .hs_n(hs2_n), .vs_n(vs2_n), .de(de2),
        .rgb(rgb2), .frame_start(fs2), .line_start(ls2),
        .underflow(uf2)
    );

    // Frame modes: 0 stream, 1 bars, 2..4 grid, 5 (after mid-frame reset) checker.
    int tgt [7] = '{0, 1, 3, 3, 3, 2, 2};

    int h, v, fc, fmode, fr, fr_pre, seq, rst_hold, cyc, eff;
    logic uf, act, ereq;
    logic [29:0] exp_v;
    int req_cnt [6];
    int de_cnt  [6];
    int vsl_cnt [6];
    int hs_fall, vs_fall, wait_cyc;
    logic hs_prev, vs_prev;

    initial begin
        pixel_rst_n = 1'b0; mode = 2'd0; pix_valid = 1'b0; pix_data = '0; underflow_clr = 1'b0;
        h = 0; v = 0; fc = 0; fmode = 0; fr = 0; seq = 0; uf = 1'b0; rst_hold = 3; cyc = 0;
        hs_fall = 0; vs_fall = 0; hs_prev = 1'b1; vs_prev = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_cnt[i] = 0; de_cnt[i] = 0; vsl_cnt[i] = 0;
        end

        while (!(fr == 5 && v == 50) && cyc < 95000) begin
            @(negedge clk);
            if (fr == 4 && v == 50 && h == 80 && rst_hold == 0) begin
                rst_hold = 2;
                fr = 5;
            end
            pixel_rst_n = (rst_hold == 0);
            if (rst_hold > 0) rst_hold--;

            if (h == 0 && v == 0)  mode = 2'(tgt[fr]);
            else if (v >= 40)      mode = 2'(tgt[fr + 1]);
            else                   mode = 2'($urandom_range(3));

            if (fr == 0 && v == 10) begin
                pix_valid     = !(h == 50 || h == 70);
                underflow_clr = (h == 60 || h == 70);
            end else begin
                pix_valid     = ($urandom_range(199) != 0);
                underflow_clr = ($urandom_range(299) == 0);
            end
            pix_data = 24'(seq);
            #1;

            eff  = (h == 0 && v == 0) ? int'(mode) : fmode;
            act  = (h < P1.hd) && (v < P1.vd);
            ereq = pixel_rst_n && act && (eff == 0);
            check_val("pix_req", 64'(pix_req), 64'(ereq));
            if (ereq) req_cnt[fr]++;
            fr_pre = fr;

            if (!pixel_rst_n) begin
                exp_v = RST_EXP;
                h = 0; v = 0; fc = 0; fmode = 0; uf = 1'b0;
            end else begin
                if (ereq && !pix_valid) uf = 1'b1;
                else if (underflow_clr)  uf = 1'b0;
                exp_v = ref_out(P1, h, v, fc, eff, pix_valid, pix_data, uf);
                fmode = eff;
                if (ereq && pix_valid) seq++;
                if (h == HT1 - 1 && v == VT1 - 1) fc = (fc + 1) % 256;
                h++;
                if (h == HT1) begin
                    h = 0; v++;
                    if (v == VT1) begin
                        v = 0; fr++;
                    end
                end
            end

            @(posedge clk);
            #1;
            cyc++;
            check_val("outputs", 64'({hs_n, vs_n, de, frame_start, line_start, underflow, rgb}), 64'(exp_v));

            if (de)    de_cnt[fr_pre]++;
            if (!vs_n) vsl_cnt[fr_pre]++;
            if (hs_prev && !hs_n) begin
                if (fr_pre >= 1 && fr_pre <= 3) check_val("hs_period", 64'(cyc - hs_fall), 64'(170));
                hs_fall = cyc;
            end
            if (!hs_prev && hs_n && fr_pre >= 1 && fr_pre <= 3)
                check_val("hs_low", 64'(cyc - hs_fall), 64'(3));
            if (vs_prev && !vs_n) begin
                if (fr_pre >= 2 && fr_pre <= 3) check_val("vs_period", 64'(cyc - vs_fall), 64'(16320));
                vs_fall = cyc;
            end
            if (!vs_prev && vs_n && fr_pre >= 1 && fr_pre <= 3)
                check_val("vs_low", 64'(cyc - vs_fall), 64'(340));
            hs_prev = hs_n;
            vs_prev = vs_n;
        end

        if (cyc >= 95000) check_val("main_timeout", 64'(fr), 64'(5));

        check_val("pops_frame0", 64'(req_cnt[0]), 64'(14490));
        for (int i = 1; i <= 3; i++) begin
            check_val("de_per_frame", 64'(de_cnt[i]), 64'(14490));
            check_val("vs_low_per_frame", 64'(vsl_cnt[i]), 64'(340));
        end

        wait_cyc = 0;
        while (!tiny_done && wait_cyc < 100000) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (!tiny_done) check_val("tiny_wait", 64'(tiny_done), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Tiny raster: grid mode across 300 frames, frame counter passes 255 -> 0.
    int h2, v2, fc2, frames2, k2;
    logic [29:0] exp2;

    initial begin
        rst2_n = 1'b0; mode2 = 2'd3; valid2 = 1'b0; data2 = '0; clr2 = 1'b0;
        h2 = 0; v2 = 0; fc2 = 0; frames2 = 0; k2 = 0;
        while (frames2 < 300 && k2 < 20000) begin
            @(negedge clk);
            rst2_n = (k2 >= 2);
            #1;
            check_val("tiny_pix_req", 64'(req2), 64'(0));
            if (!rst2_n) begin
                exp2 = RST_EXP;
                h2 = 0; v2 = 0; fc2 = 0;
            end else begin
                exp2 = ref_out(P2, h2, v2, fc2, 3, 1'b0, 24'h0, 1'b0);
                if (h2 == HT2 - 1 && v2 == VT2 - 1) fc2 = (fc2 + 1) % 256;
                h2++;
                if (h2 == HT2) begin
                    h2 = 0; v2++;
                    if (v2 == VT2) begin
                        v2 = 0; frames2++;
                    end
                end
            end
            @(posedge clk);
            #1;
            k2++;
            check_val("tiny_outputs", 64'({hs2_n, vs2_n, de2, fs2, ls2, uf2, rgb2}), 64'(exp2));
        end
        if (frames2 < 300) check_val("tiny_timeout", 64'(frames2), 64'(300));
        tiny_done = 1'b1;
    end

endmodule
